mips_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, variable-latency memory between the CPU instruction-fetch path and the data-access path. It sits between the core's `instruction_memory_*` and `data_memory_*` signals and a unified memory. It serialises accesses through a three-state FSM and returns a per-requester acknowledge that the core uses as its stall release.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mips_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mips_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_I    = 2'd1;
  localparam gnt_t GNT_D    = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise data wins ties.
module mem_arb_pick
  import mips_mem_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output gnt_t gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      gnt = last_d ? GNT_I : GNT_D;
`else
      // the data access belongs to the older instruction
      gnt = GNT_D;
`endif
    end else if (d_req) begin
      gnt = GNT_D;
    end else if (i_req) begin
      gnt = GNT_I;
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_d;
  assign unused_last_d = last_d;
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one variable-latency memory between instruction fetch and data access.
// Optional MEM_ARB_RR_EN: round-robin tie-break using a last-grant flag.
//
// state  | meaning
// IDLE   | no access in flight; grant on any request
// BUSY_I | fetch access in flight, waiting for mem_ready
// BUSY_D | data access in flight, waiting for mem_ready
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wd,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rd
);

  state_t state_q, state_d;
  gnt_t   gnt;
  logic   last_d;

  mem_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .last_d (last_d),
    .gnt    (gnt)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (state_q == IDLE && gnt != GNT_NONE) begin
      last_d <= (gnt == GNT_D);
    end
  end
`else
  assign last_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt == GNT_I)      state_d = BUSY_I;
        else if (gnt == GNT_D) state_d = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mem_we doubles as the read/write flag of the access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt == GNT_I) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
          end else if (gnt == GNT_D) begin
            mem_req  <= 1'b1;
            mem_we   <= d_we;
            mem_addr <= d_addr;
            mem_wd   <= d_wd;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            i_ack   <= 1'b1;
            i_rdata <= mem_rd;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_ack   <= 1'b1;
            if (!mem_we) d_rdata <= mem_rd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: vector table, corner sequences, random traffic.
module tb_mips_mem_arbiter;

  logic        clk, rst_n;
  logic        i_req, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack;
  logic [31:0] d_addr, d_wd, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  int total  = 0;
  int passed = 0;

  logic [31:0] exp_i_rd, exp_d_rd;
  bit          model_last_d;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_ready(mem_ready), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    int          k;
    logic [31:0] rd;
    bit          exp_d;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule from the spec, kept as a plain decision on the request pair.
  function automatic bit pick_d(input bit ir, input bit dr);
    if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
      return !model_last_d;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  // Called in the first BUSY cycle; returns in the ack cycle.
  task automatic serve(input bit exp_d, input bit exp_we, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wd, input int k, input logic [31:0] rd,
                       input logic [31:0] ird, input logic [31:0] drd, input string tag);
    chk({tag, ".mem_req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, ".mem_we"}, {31'b0, mem_we}, {31'b0, exp_we});
    chk({tag, ".mem_addr"}, mem_addr, exp_addr);
    if (exp_we) chk({tag, ".mem_wd"}, mem_wd, exp_wd);
    for (int j = 0; j < k; j++) begin
      mem_ready = 1'b0;
      tick;
      chk({tag, ".hold_req"}, {31'b0, mem_req}, 32'd1);
      chk({tag, ".hold_addr"}, mem_addr, exp_addr);
      chk({tag, ".early_ack"}, {30'b0, i_ack, d_ack}, 32'd0);
    end
    mem_ready = 1'b1;
    mem_rd    = rd;
    tick;
    mem_ready = 1'b0;
    mem_rd    = $urandom;
    chk({tag, ".i_ack"}, {31'b0, i_ack}, {31'b0, !exp_d});
    chk({tag, ".d_ack"}, {31'b0, d_ack}, {31'b0, exp_d});
    chk({tag, ".req_done"}, {30'b0, mem_req, mem_we}, 32'd0);
    chk({tag, ".i_rdata"}, i_rdata, ird);
    chk({tag, ".d_rdata"}, d_rdata, drd);
  endtask

  initial begin
    logic [31:0] rd;
    bit          w;
    bit          pi, pd, dwe_r;
    logic [31:0] ia_r, da_r, dwd_r;

    tbl[0] = '{1, 32'h0000_0040, 0, 0, 32'h0, 32'h0,         3, 32'h2008_0005,
               0, 0, 32'h0000_0040, 32'h2008_0005, 32'h0};
    tbl[1] = '{0, 32'h0, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h9999_9999,
               1, 1, 32'h0000_0100, 32'h2008_0005, 32'h0};
    tbl[2] = '{0, 32'h0, 1, 0, 32'h0000_0200, 32'h0,         1, 32'hCAFE_F00D,
               1, 0, 32'h0000_0200, 32'h2008_0005, 32'hCAFE_F00D};
    tbl[3] = '{1, 32'h0000_0044, 0, 0, 32'h0, 32'h0,         0, 32'h1111_2222,
               0, 0, 32'h0000_0044, 32'h1111_2222, 32'hCAFE_F00D};
    tbl[4] = '{0, 32'h0, 1, 0, 32'h0000_0204, 32'h0,         4, 32'h0BAD_C0DE,
               1, 0, 32'h0000_0204, 32'h1111_2222, 32'h0BAD_C0DE};
    tbl[5] = '{0, 32'h0, 1, 1, 32'h0000_0208, 32'h55AA_55AA, 2, 32'h7777_7777,
               1, 1, 32'h0000_0208, 32'h1111_2222, 32'h0BAD_C0DE};

    rst_n = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wd = 0;
    mem_ready = 0; mem_rd = 0; model_last_d = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    chk("reset.mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset.mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.mem_wd", mem_wd, 32'd0);
    chk("reset.acks", {30'b0, i_ack, d_ack}, 32'd0);
    chk("reset.rdata", i_rdata | d_rdata, 32'd0);

    for (int v = 0; v < NV; v++) begin
      i_req = tbl[v].ir; i_addr = tbl[v].ia;
      d_req = tbl[v].dr; d_we = tbl[v].dwe; d_addr = tbl[v].da; d_wd = tbl[v].dwd;
      tick;
      serve(tbl[v].exp_d, tbl[v].exp_we, tbl[v].exp_addr, tbl[v].dwd, tbl[v].k,
            tbl[v].rd, tbl[v].exp_ird, tbl[v].exp_drd, $sformatf("vec%0d", v));
      model_last_d = tbl[v].exp_d;
      i_req = 0; d_req = 0;
      tick;
      chk($sformatf("vec%0d.idle_req", v), {31'b0, mem_req}, 32'd0);
      chk($sformatf("vec%0d.single_ack", v), {30'b0, i_ack, d_ack}, 32'd0);
    end
    exp_i_rd = tbl[NV-1].exp_ird;
    exp_d_rd = tbl[NV-1].exp_drd;

    // memory completion seen while idle must be ignored
    mem_ready = 1; mem_rd = 32'h0000_1234;
    tick;
    mem_ready = 0;
    chk("spurious.acks", {30'b0, i_ack, d_ack}, 32'd0);
    chk("spurious.mem_req", {31'b0, mem_req}, 32'd0);
    chk("spurious.i_rdata", i_rdata, exp_i_rd);
    chk("spurious.d_rdata", d_rdata, exp_d_rd);

    // both requesters held for three transactions
    i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
    tick;
    for (int t = 0; t < 3; t++) begin
      w  = pick_d(1'b1, 1'b1);
      model_last_d = w;
      rd = 32'hA000_0000 + t;
      if (w) exp_d_rd = rd; else exp_i_rd = rd;
      serve(w, 0, w ? 32'h400 : 32'h300, 32'h0, 1, rd, exp_i_rd, exp_d_rd,
            $sformatf("tie%0d", t));
      if (t < 2) tick;
    end
    d_req = 0;
    tick;
    model_last_d = 0;
    exp_i_rd = 32'hA000_00FF;
    serve(0, 0, 32'h300, 32'h0, 0, 32'hA000_00FF, exp_i_rd, exp_d_rd, "tie_drain");
    i_req = 0;
    tick;
    chk("tie.idle", {31'b0, mem_req}, 32'd0);

    // reset asserted during a data write
    d_req = 1; d_we = 1; d_addr = 32'h500; d_wd = 32'h1234_5678;
    tick;
    chk("rst.granted", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.async_req", {31'b0, mem_req}, 32'd0);
    chk("rst.async_we", {31'b0, mem_we}, 32'd0);
    d_req = 0; mem_ready = 1; mem_rd = 32'hFFFF;
    tick;
    mem_ready = 0;
    chk("rst.no_ack", {30'b0, i_ack, d_ack}, 32'd0);
    #2 rst_n = 1'b1;
    tick;
    model_last_d = 0; exp_i_rd = 0; exp_d_rd = 0;
    chk("rst.after_req", {30'b0, mem_req, mem_we}, 32'd0);
    chk("rst.after_ack", {30'b0, i_ack, d_ack}, 32'd0);
    chk("rst.after_addr", mem_addr, 32'd0);
    chk("rst.after_wd", mem_wd, 32'd0);
    chk("rst.after_rdata", d_rdata, 32'd0);

    // back-to-back fetches: new request raised in the ack cycle
    i_req = 1; i_addr = 32'h80;
    tick;
    exp_i_rd = 32'h0101_0101;
    serve(0, 0, 32'h80, 32'h0, 2, 32'h0101_0101, exp_i_rd, exp_d_rd, "b2b0");
    i_addr = 32'h84;
    tick;
    exp_i_rd = 32'h0202_0202;
    serve(0, 0, 32'h84, 32'h0, 0, 32'h0202_0202, exp_i_rd, exp_d_rd, "b2b1");
    i_req = 0;
    tick;
    chk("b2b.idle", {31'b0, mem_req}, 32'd0);

    // random traffic against the transaction-level model
    pi = 0; pd = 0; ia_r = 0; da_r = 0; dwd_r = 0; dwe_r = 0;
    for (int n = 0; n < 80; n++) begin
      if (n >= 50 && !pi && !pd) break;
      if (n < 50) begin
        if (!pi && $urandom_range(0, 1) == 1) begin
          pi = 1; ia_r = $urandom & 32'hFFFF_FFFC;
        end
        if (!pd && ($urandom_range(0, 1) == 1 || !pi)) begin
          pd = 1; da_r = $urandom; dwd_r = $urandom; dwe_r = $urandom_range(0, 1);
        end
      end
      i_req = pi; i_addr = ia_r;
      d_req = pd; d_we = dwe_r; d_addr = da_r; d_wd = dwd_r;
      tick;
      w = pick_d(pi, pd);
      model_last_d = w;
      rd = $urandom;
      if (w) begin
        if (!dwe_r) exp_d_rd = rd;
      end else begin
        exp_i_rd = rd;
      end
      serve(w, w && dwe_r, w ? da_r : ia_r, dwd_r, $urandom_range(0, 4), rd,
            exp_i_rd, exp_d_rd, $sformatf("rand%0d", n));
      if (w) pd = 0; else pi = 0;
      i_req = pi; d_req = pd;
      if (!pi && !pd && $urandom_range(0, 2) == 0) begin
        tick;
        chk("rand.idle", {31'b0, mem_req}, 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
